// File: rtl/btn_pkg.sv
// btn_pkg: shared debouncer state encoding and default timing constants (12 MHz clock).
package btn_pkg;

    typedef enum logic [1:0] {
        UP         = 2'd0,
        CHECK_DOWN = 2'd1,
        DOWN       = 2'd2,
        CHECK_UP   = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_10MS_12MHZ       = 120000;
    localparam int REPEAT_DELAY_500MS_12MHZ  = 6000000;
    localparam int REPEAT_PERIOD_125MS_12MHZ = 1500000;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous pin, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q1,
    output logic q2
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= RST_VAL;
            q2 <= RST_VAL;
        end else begin
            q1 <= d;
            q2 <= q1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: polarity normalise, synchronise and debounce a pushbutton into a level plus press/release strobes.
// Define BUTTON_DEBOUNCER_AUTO_REPEAT_EN to add auto-repeat press strobes while the button is held.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS_12MHZ,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_125MS_12MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 24'hFFFFFF || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_debouncer: illegal timing parameters");
    end

    btn_state_t    state, state_n;
    logic [CW-1:0] count, count_n;
    logic          sync_q1, sync_q2;
    logic          press_n, release_n, rpt_fire;

    sync_2ff #(.RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ((ACTIVE_LOW != 0) ? ~btn_raw : btn_raw),
        .q1  (sync_q1),
        .q2  (sync_q2)
    );

    always_comb begin
        state_n   = state;
        count_n   = '0;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            UP:         state_n = sync_q2 ? CHECK_DOWN : UP;
            CHECK_DOWN: begin
                count_n = count + 1'b1;
                if (!sync_q2) state_n = UP;
                else if (count == CMAX) begin
                    state_n = DOWN;
                    press_n = 1'b1;
                end
            end
            DOWN:       state_n = sync_q2 ? DOWN : CHECK_UP;
            CHECK_UP:   begin
                count_n = count + 1'b1;
                if (sync_q2) state_n = DOWN;
                else if (count == CMAX) begin
                    state_n   = UP;
                    release_n = 1'b1;
                end
            end
            default:    state_n = UP;
        endcase
    end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    localparam int RMAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAXV + 1);
    localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);
    logic [RW-1:0] rcnt;
    logic          rpt;
    // First repeat waits the long delay, later ones the short period.
    assign rpt_fire = (state == DOWN) && sync_q2 && (rcnt == (rpt ? RP_MAX : RD_MAX));
    always_ff @(posedge clk) begin
        if (rst || state != DOWN) begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end else if (rpt_fire) begin
            rcnt <= '0;
            rpt  <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= UP;
            count         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            press_pulse   <= press_n | rpt_fire;
            release_pulse <= release_n;
        end
    end

    assign btn_level = (state == DOWN) || (state == CHECK_UP);

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of the debouncer with DEBOUNCE_CYCLES=4, active-low button.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b1;
    logic btn_level, press_pulse, release_pulse;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive happened at the current negedge; the strobe must appear exactly n negedges later.
    task automatic expect_strobe(input string tag, input int n, input bit is_press);
        int early = 0;
        repeat (n - 1) begin
            @(negedge clk);
            early += int'(press_pulse | release_pulse);
        end
        @(negedge clk);
        check({tag, "_early"}, early, 0);
        check({tag, "_pulse"}, is_press ? press_pulse : release_pulse, 1);
        check({tag, "_other"}, is_press ? release_pulse : press_pulse, 0);
        check({tag, "_level"}, btn_level, is_press);
        @(negedge clk);
        check({tag, "_width"}, press_pulse | release_pulse, 0);
    endtask

    initial begin
        int quiet;
        int rpt_cnt;
        logic [31:0] rpt_mask;
        repeat (3) @(negedge clk);
        check("rst_level", btn_level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_state", dut.state, 0);
        rst = 1'b0;
        quiet = 0;
        repeat (5) begin
            @(negedge clk);
            quiet += int'(press_pulse | release_pulse | btn_level);
        end
        check("idle_quiet", quiet, 0);

        btn_raw = 1'b0;
        expect_strobe("press", 7, 1'b1);
        repeat (2) @(negedge clk);
        btn_raw = 1'b1;
        expect_strobe("release", 7, 1'b0);

        btn_raw = 1'b0;
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            quiet += int'(press_pulse | release_pulse);
        end
        btn_raw = 1'b1;
        @(negedge clk);
        quiet += int'(press_pulse | release_pulse);
        btn_raw = 1'b0;
        check("bounce_glitch", quiet, 0);
        expect_strobe("bounce", 7, 1'b1);
        btn_raw = 1'b1;
        expect_strobe("release2", 7, 1'b0);

        btn_raw = 1'b0;
        quiet = 0;
        repeat (5) begin
            @(negedge clk);
            quiet += int'(press_pulse | release_pulse);
        end
        check("midq_count", dut.count, 2);
        rst = 1'b1;
        @(negedge clk);
        quiet += int'(press_pulse | release_pulse);
        check("midq_quiet", quiet, 0);
        check("midq_state", dut.state, 0);
        rst = 1'b0;
        expect_strobe("midq", 7, 1'b1);
        btn_raw = 1'b1;
        expect_strobe("release3", 7, 1'b0);

        btn_raw = 1'b0;
        expect_strobe("hold", 7, 1'b1);
        rpt_cnt = 0;
        rpt_mask = '0;
        // Offset 1 was already sampled inside expect_strobe (width check).
        for (int i = 2; i <= 28; i++) begin
            @(negedge clk);
            if (press_pulse) begin
                rpt_cnt++;
                rpt_mask[i] = 1'b1;
            end
        end
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        check("rpt_count", rpt_cnt, 7);
        check("rpt_mask", rpt_mask, 32'h1249_2400);
`else
        check("rpt_count", rpt_cnt, 0);
        check("rpt_mask", rpt_mask, 32'h0);
`endif
        check("hold_level", btn_level, 1);
        btn_raw = 1'b1;
        expect_strobe("hold_release", 7, 1'b0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            quiet += int'(press_pulse | release_pulse | btn_level);
        end
        check("final_quiet", quiet, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
